// File: rtl/ifns_pkg.sv
// ifns_pkg: shared definitions for the multi-cycle IFNS decoder.
//   fib_weight(i)        - Fibonacci weight F(i), F(1)=F(2)=1. Returned
//                          FIB_W wide; callers truncate to their ACC_W.
//                          Sums are taken modulo 2^ACC_W, so the
//                          truncation is exact.
//   num_groups(cw, dpc)  - ceil(cw/dpc), the number of digit groups.
//   ifns_dec_state_t     - decoder FSM states.
package ifns_pkg;

  localparam int unsigned FIB_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } ifns_dec_state_t;

  function automatic logic [FIB_W-1:0] fib_weight(input int unsigned i);
    logic [FIB_W-1:0] f_prev;
    logic [FIB_W-1:0] f_cur;
    logic [FIB_W-1:0] f_tmp;
    f_prev = '0;          // F(0)
    f_cur  = FIB_W'(1);   // F(1)
    if (i == 0) return '0;
    for (int unsigned n = 2; n <= i; n++) begin
      f_tmp  = f_cur + f_prev;
      f_prev = f_cur;
      f_cur  = f_tmp;
    end
    return f_cur;
  endfunction

  function automatic int unsigned num_groups(input int unsigned code_w,
                                             input int unsigned dpc);
    return (code_w + dpc - 1) / dpc;
  endfunction

endpackage

// File: rtl/ifns_group_sum.sv
// ifns_group_sum: combinational weighted sum of one group of
// DIGITS_PER_CYC Fibonacci digits.
//   code_q [CODE_W:1]  captured codeword, bit i has weight F(i)
//   grp    [GRP_W-1:0] group index k; digits k*DPC+1 .. (k+1)*DPC
//   sum    [ACC_W-1:0] sum of code_q[i]*F(i) over the group
module ifns_group_sum
  import ifns_pkg::*;
#(
  parameter int unsigned CODE_W         = 33,
  parameter int unsigned DIGITS_PER_CYC = 4,
  parameter int unsigned ACC_W          = 25,
  parameter int unsigned GRP_W          = 4
) (
  input  logic [CODE_W:1]   code_q,
  input  logic [GRP_W-1:0]  grp,
  output logic [ACC_W-1:0]  sum
);

  localparam int unsigned NGRP  = num_groups(CODE_W, DIGITS_PER_CYC);
  localparam int unsigned PAD_W = NGRP * DIGITS_PER_CYC;
  localparam int unsigned IDX_W = (PAD_W > 1) ? $clog2(PAD_W) : 1;

  // Codeword zero-padded to a whole number of groups; pad digits and
  // their weights are zero so the last (short) group needs no special case.
  logic [PAD_W-1:0] code_pad;
  logic [ACC_W-1:0] wtab [PAD_W];
  logic [ACC_W-1:0] slot;

  assign code_pad = PAD_W'(code_q);

  for (genvar p = 0; p < PAD_W; p++) begin : g_wtab
    if (p < CODE_W) begin : g_live
      assign wtab[p] = ACC_W'(fib_weight(p + 1));
    end else begin : g_pad
      assign wtab[p] = '0;
    end
  end

  // One adder per digit slot: each slot picks its digit/weight for the
  // active group with an AND-OR mux, then the DPC slot values are summed.
  always_comb begin
    sum  = '0;
    slot = '0;
    for (int unsigned j = 0; j < DIGITS_PER_CYC; j++) begin
      slot = '0;
      for (int unsigned g = 0; g < NGRP; g++) begin
        if ((grp == GRP_W'(g)) && code_pad[IDX_W'(g * DIGITS_PER_CYC + j)]) begin
          slot = slot | wtab[IDX_W'(g * DIGITS_PER_CYC + j)];
        end
      end
      sum = sum + slot;
    end
  end

endmodule

// File: rtl/ifns_decoder_mc.sv
// ifns_decoder_mc: multi-cycle Fibonacci-numeral-system (IFNS) decoder for
// the receive side of a CAC bus link. A codeword is accepted in IDLE, its
// digits are accumulated DIGITS_PER_CYC at a time (LSB group first) in BUSY,
// and the result is presented in DONE until the consumer takes it.
//   clock      rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   codein valid
//   in_ready   decoder can accept a codeword (IDLE and out of reset)
//   codein     codeword [CODE_W:1], bit i weight F(i)
//   out_valid  dataout holds a decoded word
//   out_ready  consumer accepts dataout
//   dataout    decoded value modulo 2^DATA_W
//   err        (only with IFNS_DEC_ERR_CHECK_EN) full sum >= 2^DATA_W
// Optional build macro: IFNS_DEC_ERR_CHECK_EN adds the err output.
module ifns_decoder_mc
  import ifns_pkg::*;
#(
  parameter int unsigned CODE_W         = 33,
  parameter int unsigned DATA_W         = 23,
  parameter int unsigned DIGITS_PER_CYC = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W:1]   codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout
`ifdef IFNS_DEC_ERR_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned ACC_W = DATA_W + 2;
  localparam int unsigned NGRP  = num_groups(CODE_W, DIGITS_PER_CYC);
  localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

  ifns_dec_state_t  state;
  ifns_dec_state_t  state_d;
  logic [CODE_W:1]  code_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] grp_sum;
  logic [ACC_W-1:0] acc_next;
  logic [GRP_W-1:0] grp;
  logic             accept;
  logic             deliver;
  logic             last_grp;

  // in_ready is gated by rst_n so it reads 0 for the whole reset window.
  assign in_ready = rst_n && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;
  assign last_grp = (grp == LAST_GRP);
  assign acc_next = acc + grp_sum;

  ifns_group_sum #(
    .CODE_W         (CODE_W),
    .DIGITS_PER_CYC (DIGITS_PER_CYC),
    .ACC_W          (ACC_W),
    .GRP_W          (GRP_W)
  ) u_group_sum (
    .code_q (code_q),
    .grp    (grp),
    .sum    (grp_sum)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept)   state_d = BUSY;
      BUSY:    if (last_grp) state_d = DONE;
      DONE:    if (deliver)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      acc       <= '0;
      grp       <= '0;
      dataout   <= '0;
      out_valid <= 1'b0;
`ifdef IFNS_DEC_ERR_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            code_q <= codein;
            acc    <= '0;
            grp    <= '0;
          end
        end
        BUSY: begin
          acc <= acc_next;
          grp <= grp + 1'b1;
          // Final group: publish the completed sum on this same edge.
          if (last_grp) begin
            dataout   <= acc_next[DATA_W-1:0];
            out_valid <= 1'b1;
`ifdef IFNS_DEC_ERR_CHECK_EN
            err       <= |acc_next[ACC_W-1:DATA_W];
`endif
          end
        end
        DONE: begin
          if (deliver) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifndef IFNS_DEC_ERR_CHECK_EN
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_next[ACC_W-1:DATA_W];
`endif

endmodule

// File: tb/tb_ifns_decoder_mc.sv
// tb_ifns_decoder_mc: self-checking bench for ifns_decoder_mc. Three
// instances (DIGITS_PER_CYC = 1, 4, 33) share clock and reset; instance 1
// (DPC=4) carries the directed table and corner sequences, all three get
// random codewords checked against a plain weighted-sum reference.
module tb_ifns_decoder_mc;

  localparam int unsigned NI = 3;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [33:1] codein    [NI];
  logic [22:0] dataout   [NI];
`ifdef IFNS_DEC_ERR_CHECK_EN
  logic        err       [NI];
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock = ~clock;

  for (genvar n = 0; n < NI; n++) begin : g_dut
    localparam int unsigned DPC = (n == 0) ? 1 : ((n == 1) ? 4 : 33);
    ifns_decoder_mc #(
      .CODE_W         (33),
      .DATA_W         (23),
      .DIGITS_PER_CYC (DPC)
    ) u_dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .in_valid  (in_valid[n]),
      .in_ready  (in_ready[n]),
      .codein    (codein[n]),
      .out_valid (out_valid[n]),
      .out_ready (out_ready[n]),
      .dataout   (dataout[n])
`ifdef IFNS_DEC_ERR_CHECK_EN
      ,
      .err       (err[n])
`endif
    );
  end

  typedef struct {
    logic [33:1] code;
    logic [22:0] data;
    logic        err;
  } vec_t;

  vec_t        vecs [10];
  int unsigned exp_lat [NI];

  // Reference: value = sum of c[i]*F(i), built from the Fibonacci recurrence.
  function automatic longint unsigned ref_sum(input logic [33:1] c);
    logic [32:0]      v;
    longint unsigned  s;
    longint unsigned  fa;
    longint unsigned  fb;
    longint unsigned  t;
    v  = c;
    s  = 0;
    fa = 1;
    fb = 0;
    for (int i = 0; i < 33; i++) begin
      if (v[0]) s += fa;
      t  = fa + fb;
      fb = fa;
      fa = t;
      v  = v >> 1;
    end
    return s;
  endfunction

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Waits for in_ready, presents code for one accept edge, then counts
  // cycles until out_valid. Returns with time just after a rising edge.
  task automatic start_txn(input logic [1:0] inst, input logic [33:1] code,
                           output int unsigned lat);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      ok = in_ready[inst];
    end
    check("in_ready_before_accept", 64'(ok), 64'd1);
    in_valid[inst] = 1'b1;
    codein[inst]   = code;
    @(posedge clock);
    #1;
    in_valid[inst] = 1'b0;
    lat = 0;
    while (lat < 100 && !out_valid[inst]) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic finish_txn(input logic [1:0] inst);
    @(negedge clock);
    out_ready[inst] = 1'b1;
    @(posedge clock);
    #1;
    check("out_valid_after_handshake", 64'(out_valid[inst]), 64'd0);
    check("in_ready_after_handshake", 64'(in_ready[inst]), 64'd1);
    out_ready[inst] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned     lat;
    logic [33:1]     code;
    longint unsigned s;

    for (int n = 0; n < NI; n++) begin
      in_valid[n]  = 1'b0;
      out_ready[n] = 1'b0;
      codein[n]    = '0;
    end
    exp_lat[0] = 33;
    exp_lat[1] = 9;
    exp_lat[2] = 1;

    vecs[0] = '{code: 33'h0_0000_0000, data: 23'd0,       err: 1'b0};
    vecs[1] = '{code: 33'h0_0000_0005, data: 23'd3,       err: 1'b0};
    vecs[2] = '{code: 33'h1_0000_0000, data: 23'd3524578, err: 1'b0};
    vecs[3] = '{code: 33'h1_FFFF_FFFF, data: 23'd838856,  err: 1'b1};
    vecs[4] = '{code: 33'h0_0000_0001, data: 23'd1,       err: 1'b0};
    vecs[5] = '{code: 33'h0_0000_0002, data: 23'd1,       err: 1'b0};
    vecs[6] = '{code: 33'h0_8000_0000, data: 23'd2178309, err: 1'b0};
    vecs[7] = '{code: 33'h1_8000_0000, data: 23'd5702887, err: 1'b0};
    vecs[8] = '{code: 33'h0_0000_0010, data: 23'd5,       err: 1'b0};
    vecs[9] = '{code: 33'h1_F000_0000, data: 23'd6817,    err: 1'b1};

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_in_ready", 64'(in_ready[1]), 64'd0);
    check("reset_out_valid", 64'(out_valid[1]), 64'd0);
    check("reset_dataout", 64'(dataout[1]), 64'd0);
`ifdef IFNS_DEC_ERR_CHECK_EN
    check("reset_err", 64'(err[1]), 64'd0);
`endif
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready[1]), 64'd1);

    // Directed table on the DPC=4 instance
    for (int v = 0; v < 10; v++) begin
      start_txn(2'd1, vecs[v].code, lat);
      check("table_latency", 64'(lat), 64'd9);
      check("table_dataout", 64'(dataout[1]), 64'(vecs[v].data));
`ifdef IFNS_DEC_ERR_CHECK_EN
      check("table_err", 64'(err[1]), 64'(vecs[v].err));
`endif
      finish_txn(2'd1);
    end

    // Back-pressure in DONE with in_valid/codein activity
    start_txn(2'd1, 33'h0_0000_0005, lat);
    check("hold_latency", 64'(lat), 64'd9);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      in_valid[1] = (c % 2 == 0);
      codein[1]   = {1'($urandom_range(1, 0)), 32'($urandom)};
      @(posedge clock);
      #1;
      check("hold_out_valid", 64'(out_valid[1]), 64'd1);
      check("hold_dataout", 64'(dataout[1]), 64'd3);
      check("hold_in_ready", 64'(in_ready[1]), 64'd0);
    end
    @(negedge clock);
    in_valid[1] = 1'b0;
    finish_txn(2'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      check("post_release_no_output", 64'(out_valid[1]), 64'd0);
    end

    // Asynchronous reset during BUSY (cycle 4 after accept)
    @(negedge clock);
    in_valid[1] = 1'b1;
    codein[1]   = 33'h1_FFFF_FFFF;
    @(posedge clock);
    #1;
    in_valid[1] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid[1]), 64'd0);
    check("abort_dataout", 64'(dataout[1]), 64'd0);
    check("abort_in_ready", 64'(in_ready[1]), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    start_txn(2'd1, 33'h0_0000_0005, lat);
    check("after_abort_latency", 64'(lat), 64'd9);
    check("after_abort_dataout", 64'(dataout[1]), 64'd3);
    finish_txn(2'd1);

    // Random codewords on every DIGITS_PER_CYC variant
    for (int n = 0; n < NI; n++) begin
      for (int r = 0; r < 6; r++) begin
        if (r < 3) code = 33'($urandom & 32'h007F_FFFF);
        else       code = {1'($urandom_range(1, 0)), 32'($urandom)};
        s = ref_sum(code);
        start_txn(2'(n), code, lat);
        check("rand_latency", 64'(lat), 64'(exp_lat[n]));
        check("rand_dataout", 64'(dataout[n]), s % 64'd8388608);
`ifdef IFNS_DEC_ERR_CHECK_EN
        check("rand_err", 64'(err[n]), (s >= 64'd8388608) ? 64'd1 : 64'd0);
`endif
        finish_txn(2'(n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
